// File: rtl/mips_regfile_wb.sv
`default_nettype none
// ============================================================================
//  Module   : mips_regfile_wb
//  Purpose  : 32x32 MIPS register file, one-entry write-back staging register,
//             staging bypass on two combinational read ports.
//             Optional MIPS_REGFILE_SAME_CYCLE_BYPASS_EN forwards the request
//             of the current cycle to the read ports.
//  Revision : 1.0  initial release
// ============================================================================
module mips_regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_reg,
    output logic [CNT_W-1:0]  commit_count
);

    localparam int c_NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [c_NREGS];
    logic              r_wb_valid;
    logic [ADDR_W-1:0] r_wb_reg;
    logic [DATA_W-1:0] r_wb_data;
    logic [CNT_W-1:0]  r_commit_count;
    logic              w_stage;

    // Requests to register 0 never enter staging, so array[0] stays zero.
    assign w_stage = wr_en && (write_register != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_valid     <= 1'b0;
            r_wb_reg       <= '0;
            r_wb_data      <= '0;
            r_commit_count <= '0;
        end else begin
            if (r_wb_valid) begin
                r_regs[r_wb_reg] <= r_wb_data;
                r_commit_count   <= r_commit_count + CNT_W'(1);
            end
            r_wb_valid <= w_stage;
            if (w_stage) begin
                r_wb_reg  <= write_register;
                r_wb_data <= write_data;
            end
        end
    end

    logic [1:0][DATA_W-1:0] w_rd_data;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_rd_port
            logic [ADDR_W-1:0] w_idx;
            assign w_idx = (g == 0) ? read_reg1 : read_reg2;
            assign w_rd_data[g] =
                (w_idx == '0) ? '0 :
`ifdef MIPS_REGFILE_SAME_CYCLE_BYPASS_EN
                (wr_en && (write_register == w_idx)) ? write_data :
`endif
                (r_wb_valid && (r_wb_reg == w_idx)) ? r_wb_data :
                r_regs[w_idx];
        end
    endgenerate

    assign read_data1   = w_rd_data[0];
    assign read_data2   = w_rd_data[1];
    assign wb_valid     = r_wb_valid;
    assign wb_reg       = r_wb_reg;
    assign commit_count = r_commit_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_regfile_wb
//  Purpose  : Directed scoreboard bench for mips_regfile_wb.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_regfile_wb;

`ifdef MIPS_REGFILE_SAME_CYCLE_BYPASS_EN
    localparam bit c_SCB = 1'b1;
`else
    localparam bit c_SCB = 1'b0;
`endif

    localparam logic [2:0] c_K_RD1 = 3'd0;
    localparam logic [2:0] c_K_RD2 = 3'd1;
    localparam logic [2:0] c_K_WBV = 3'd2;
    localparam logic [2:0] c_K_WBR = 3'd3;
    localparam logic [2:0] c_K_CNT = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] exp;
        logic [15:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [15:0] commit_count;

    exp_t q_exp[$];
    int   checks = 0;
    int   errors = 0;

    mips_regfile_wb dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .write_register (write_register),
        .write_data     (write_data),
        .read_reg1      (read_reg1),
        .read_reg2      (read_reg2),
        .read_data1     (read_data1),
        .read_data2     (read_data2),
        .wb_valid       (wb_valid),
        .wb_reg         (wb_reg),
        .commit_count   (commit_count)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input logic [2:0] kind, input logic [31:0] exp, input int tag);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = 16'(tag);
        q_exp.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs are combinational; they are stable mid-cycle, so compare at negedge.
    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            string       nm;
            e = q_exp.pop_front();
            case (e.kind)
                c_K_RD1: begin act = read_data1;          nm = "read_data1";   end
                c_K_RD2: begin act = read_data2;          nm = "read_data2";   end
                c_K_WBV: begin act = {31'b0, wb_valid};   nm = "wb_valid";     end
                c_K_WBR: begin act = {27'b0, wb_reg};     nm = "wb_reg";       end
                default: begin act = {16'b0, commit_count}; nm = "commit_count"; end
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", nm, e.tag, act, e.exp);
            end
        end
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; write_register = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state across every index on both ports.
        expect_val(c_K_WBV, 32'd0, 0);
        expect_val(c_K_CNT, 32'd0, 0);
        expect_val(c_K_WBR, 32'd0, 0);
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            expect_val(c_K_RD1, 32'd0, 1);
            expect_val(c_K_RD2, 32'd0, 1);
            tick();
        end

        // Single write r5 = DEADBEEF: staging bypass, then array.
        wr_en = 1'b1; write_register = 5'd5; write_data = 32'hDEADBEEF; read_reg1 = 5'd5;
        expect_val(c_K_RD1, c_SCB ? 32'hDEADBEEF : 32'd0, 10);
        tick();
        wr_en = 1'b0;
        expect_val(c_K_WBV, 32'd1, 11);
        expect_val(c_K_WBR, 32'd5, 11);
        expect_val(c_K_RD1, 32'hDEADBEEF, 11);
        expect_val(c_K_CNT, 32'd0, 11);
        tick();
        expect_val(c_K_WBV, 32'd0, 12);
        expect_val(c_K_RD1, 32'hDEADBEEF, 12);
        expect_val(c_K_CNT, 32'd1, 12);
        tick();

        // Write to r0 is dropped.
        wr_en = 1'b1; write_register = 5'd0; write_data = 32'h12345678; read_reg1 = 5'd0;
        expect_val(c_K_RD1, 32'd0, 20);
        tick();
        wr_en = 1'b0;
        expect_val(c_K_WBV, 32'd0, 21);
        expect_val(c_K_RD1, 32'd0, 21);
        expect_val(c_K_CNT, 32'd1, 21);
        tick();
        expect_val(c_K_CNT, 32'd1, 22);
        tick();

        // Back-to-back writes to r7.
        wr_en = 1'b1; write_register = 5'd7; write_data = 32'h1; read_reg2 = 5'd7;
        expect_val(c_K_RD2, c_SCB ? 32'h1 : 32'h0, 30);
        tick();
        write_data = 32'h2;
        expect_val(c_K_RD2, c_SCB ? 32'h2 : 32'h1, 31);
        expect_val(c_K_CNT, 32'd1, 31);
        tick();
        wr_en = 1'b0;
        expect_val(c_K_RD2, 32'h2, 32);
        expect_val(c_K_WBV, 32'd1, 32);
        expect_val(c_K_WBR, 32'd7, 32);
        expect_val(c_K_CNT, 32'd2, 32);
        tick();
        read_reg1 = 5'd5;
        expect_val(c_K_RD2, 32'h2, 33);
        expect_val(c_K_RD1, 32'hDEADBEEF, 33);
        expect_val(c_K_WBV, 32'd0, 33);
        expect_val(c_K_CNT, 32'd3, 33);
        tick();

        // Staged write discarded by reset.
        wr_en = 1'b1; write_register = 5'd9; write_data = 32'hAAAA0000; read_reg1 = 5'd9;
        tick();
        wr_en = 1'b0; reset = 1'b1;
        expect_val(c_K_WBV, 32'd1, 40);
        expect_val(c_K_RD1, 32'hAAAA0000, 40);
        tick();
        reset = 1'b0; read_reg2 = 5'd5;
        expect_val(c_K_RD1, 32'd0, 41);
        expect_val(c_K_RD2, 32'd0, 41);
        expect_val(c_K_WBV, 32'd0, 41);
        expect_val(c_K_WBR, 32'd0, 41);
        expect_val(c_K_CNT, 32'd0, 41);
        tick();
        expect_val(c_K_RD1, 32'd0, 42);
        expect_val(c_K_CNT, 32'd0, 42);
        tick();

        // Write-then-read of r3 in the same cycle.
        wr_en = 1'b1; write_register = 5'd3; write_data = 32'h55; read_reg1 = 5'd3;
        expect_val(c_K_RD1, c_SCB ? 32'h55 : 32'h0, 50);
        tick();
        wr_en = 1'b0;
        expect_val(c_K_RD1, 32'h55, 51);
        tick();
        expect_val(c_K_RD1, 32'h55, 52);
        expect_val(c_K_CNT, 32'd1, 52);
        tick();
        tick();

        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_regfile_wb.md
Name: mips_regfile_wb

Overview:
- Consumer end of the 5-bit write-register select produced by the datapath's rt/rd destination mux.
- Provides a 32x32 MIPS register file with one write port and two combinational read ports.
- Write requests pass through a one-entry write-back staging register and commit to the array one cycle later.
- Read ports bypass from the staging register, so software sees writes in order.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width; 2**ADDR_W registers
- CNT_W, 16, width of the commit counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write request valid this cycle (RegWrite)
- write_register  input  ADDR_W  destination register index from the destination mux
- write_data  input  DATA_W  data to write
- read_reg1  input  ADDR_W  read port 1 index (rs)
- read_reg2  input  ADDR_W  read port 2 index (rt)
- read_data1  output  DATA_W  read port 1 data, combinational
- read_data2  output  DATA_W  read port 2 data, combinational
- wb_valid  output  1  staging register holds an uncommitted write
- wb_reg  output  ADDR_W  index held in staging register
- commit_count  output  CNT_W  number of writes committed to the array since reset

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- On reset (rising edge with reset=1):
  - all 32 array entries are cleared to 0
  - wb_valid=0, wb_reg=0, staged data=0, commit_count=0
  - reset has priority over every other event
  - a write pending in staging at reset is discarded, not committed
- Staging, at each edge with reset=0:
  - if wr_en=1 and write_register!=0: wb_valid<=1, wb_reg<=write_register, wb_data<=write_data
  - otherwise: wb_valid<=0
- Commit, at the same edge: if wb_valid=1 (the previous stage contents), array[wb_reg]<=wb_data and commit_count<=commit_count+1.
- Latency: a request sampled at edge N commits to the array at edge N+1.
- Back-to-back requests: one request per cycle is accepted with no stall. Commit and new staging happen on the same edge. Two writes to the same register in consecutive cycles leave the later value in the array after both commit.
- Register 0:
  - reads of index 0 always return 0
  - write requests to index 0 are dropped: not staged, wb_valid=0 next cycle, not counted
  - array[0] is never written
- Read ports (combinational, evaluated independently per port):
  - index 0 -> 0
  - else if wb_valid=1 and wb_reg==index -> wb_data (bypass)
  - else -> array[index]
- Counter: commit_count wraps modulo 2**CNT_W with no saturation or flag.
- Undefined-free: no X on any output after the first reset edge.

Optional Feature:
- Macro: MIPS_REGFILE_SAME_CYCLE_BYPASS_EN
- Defined: read priority becomes:
  - index 0 -> 0
  - else if wr_en=1 and write_register==index -> write_data, for the current-cycle request
  - else staging bypass
  - else array
  - This gives a write-then-read in the same cycle the new value, a combinational path from write_data to read_data.
- Undefined: the current-cycle request is invisible to read ports until the following cycle, when it is in staging.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then read all 32 indices on both ports -> every read_data=0, wb_valid=0, commit_count=0.
- wr_en=1, write_register=5, write_data=0xDEADBEEF at cycle 1; wr_en=0 after:
  - cycle 2: wb_valid=1, wb_reg=5, read_reg1=5 gives 0xDEADBEEF via bypass
  - cycle 3: wb_valid=0, read still 0xDEADBEEF from the array, commit_count=1
- Write reg 0 with 0x12345678 -> next cycle wb_valid=0, read_reg1=0 gives 0, commit_count unchanged.
- Consecutive writes r7=0x1 then r7=0x2, read_reg2=7 -> 0x1 during cycle after the first, 0x2 thereafter; commit_count=2.
- Stage r9=0xAAAA0000, assert reset on the following edge -> read_reg1=9 gives 0, commit_count=0, wb_valid=0.
- With MIPS_REGFILE_SAME_CYCLE_BYPASS_EN: wr_en=1, write_register=3, write_data=0x55 with read_reg1=3 in the same cycle -> read_data1=0x55 immediately. Without the macro: old value 0 that cycle, 0x55 next cycle.
